// File: rtl/readfifo_ptrctl.sv
// readfifo_ptrctl: pointer/commit control for the 256x8 tag read-response FIFO
module readfifo_ptrctl (
  input  logic       readbitclk,
  input  logic       reset,
  input  logic       fifo_start,
  input  logic       fifo_nextout,
  input  logic       pkt_done,
  input  logic       commit,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  output logic [7:0] count,
  output logic       empty,
  output logic       full,
  output logic       underrun,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, ARM, STREAM} state_t;
  state_t     r_state;
  logic       r_start_q;
  logic [7:0] r_start_ptr;
  logic [7:0] r_rd_ptr;
  logic [7:0] r_wr_ptr;
  logic [7:0] r_hold;
  logic       r_hold_valid;
  logic       r_underrun;
  logic       r_overflow;
  logic       w_start_rise;
  logic       w_drain;
  logic       w_accept;
  assign w_start_rise = fifo_start & ~r_start_q;
  assign w_drain      = (r_state == IDLE) & r_hold_valid;
  assign empty        = r_rd_ptr == r_wr_ptr;
  assign full         = (r_wr_ptr + 8'd1) == r_start_ptr;
  assign count        = r_wr_ptr - r_start_ptr;
  // the hold register frees up in a drain cycle, so a new byte can land on the same edge
  assign wr_ready     = ~r_hold_valid | w_drain;
  assign w_accept     = wr_valid & wr_ready;
  assign mem_we       = w_drain & ~full;
  assign mem_addr     = w_drain ? r_wr_ptr : r_rd_ptr;
  assign mem_wdata    = r_hold;
  assign underrun     = r_underrun;
  assign overflow     = r_overflow;
  // read side: packet start commits or rewinds, then nextout walks rd_ptr
  always_ff @(posedge readbitclk or posedge reset)
    if (reset) begin
      r_state     <= IDLE;
      r_start_q   <= 1'b0;
      r_start_ptr <= 8'd0;
      r_rd_ptr    <= 8'd0;
      r_underrun  <= 1'b0;
    end else begin
      r_start_q <= fifo_start;
      if (w_start_rise) begin
        r_state <= ARM;
        if (commit) r_start_ptr <= r_rd_ptr;
        else r_rd_ptr <= r_start_ptr;
      end else if (r_state != IDLE && pkt_done) begin
        r_state <= IDLE;
      end else if (fifo_nextout) begin
        if (r_state == ARM) r_state <= STREAM;
        else if (r_state == STREAM) begin
          if (empty) r_underrun <= 1'b1;
          else r_rd_ptr <= r_rd_ptr + 8'd1;
        end
      end
    end
  // write side: hold register drains into the RAM only while no packet is in flight
  always_ff @(posedge readbitclk or posedge reset)
    if (reset) begin
      r_wr_ptr     <= 8'd0;
      r_hold       <= 8'd0;
      r_hold_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_drain) begin
        if (full) r_overflow <= 1'b1;
        else r_wr_ptr <= r_wr_ptr + 8'd1;
      end
      if (w_accept) begin
        r_hold       <= wr_data;
        r_hold_valid <= 1'b1;
      end else if (w_drain) begin
        r_hold_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_readfifo_ptrctl.sv
// tb_readfifo_ptrctl: directed self-checking bench for readfifo_ptrctl
module tb_readfifo_ptrctl;
  logic       readbitclk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_start = 1'b0;
  logic       fifo_nextout = 1'b0;
  logic       pkt_done = 1'b0;
  logic       commit = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_ready;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] count;
  logic       empty;
  logic       full;
  logic       underrun;
  logic       overflow;
  int         n_checks = 0;
  int         n_errors = 0;
  readfifo_ptrctl dut (
    .readbitclk(readbitclk), .reset(reset), .fifo_start(fifo_start),
    .fifo_nextout(fifo_nextout), .pkt_done(pkt_done), .commit(commit),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .count(count), .empty(empty), .full(full),
    .underrun(underrun), .overflow(overflow)
  );
  always #5 readbitclk = ~readbitclk;
  task automatic tick();
    @(posedge readbitclk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
  task automatic pulse_start(input logic c);
    fifo_start = 1'b1;
    commit = c;
    tick();
    fifo_start = 1'b0;
    tick();
  endtask
  task automatic pulse_next();
    fifo_nextout = 1'b1;
    tick();
    fifo_nextout = 1'b0;
  endtask
  task automatic pulse_done();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
  endtask
  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++; if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready); end
    n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    n_checks++; if (mem_addr !== 8'd0) begin n_errors++; $display("FAIL rst_mem_addr got %0d exp 0", mem_addr); end
    n_checks++; if (count !== 8'd0) begin n_errors++; $display("FAIL rst_count got %0d exp 0", count); end
    n_checks++; if ({empty, full, underrun, overflow} !== 4'b1000) begin n_errors++; $display("FAIL rst_flags got %b exp 1000", {empty, full, underrun, overflow}); end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_write5();
    for (int i = 0; i <= 5; i++) begin
      wr_valid = (i < 5);
      wr_data = 8'hA0 + 8'(i);
      if (i < 5) begin
        n_checks++; if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL w5_ready[%0d] got %b exp 1", i, wr_ready); end
      end
      if (i > 0) begin
        n_checks++; if (mem_we !== 1'b1) begin n_errors++; $display("FAIL w5_we[%0d] got %b exp 1", i, mem_we); end
        n_checks++; if (mem_addr !== 8'(i - 1)) begin n_errors++; $display("FAIL w5_addr[%0d] got %0d exp %0d", i, mem_addr, i - 1); end
        n_checks++; if (mem_wdata !== 8'hA0 + 8'(i - 1)) begin n_errors++; $display("FAIL w5_data[%0d] got %h exp %h", i, mem_wdata, 8'hA0 + 8'(i - 1)); end
      end
      tick();
    end
    wr_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL w5_we_end got %b exp 0", mem_we); end
    n_checks++; if (count !== 8'd5) begin n_errors++; $display("FAIL w5_count got %0d exp 5", count); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL w5_empty got %b exp 0", empty); end
  endtask
  task automatic test_commit_stream();
    pulse_start(1'b1);
    for (int k = 0; k < 3; k++) begin
      pulse_next();
      n_checks++; if (mem_addr !== 8'(k)) begin n_errors++; $display("FAIL cs_addr[%0d] got %0d exp %0d", k, mem_addr, k); end
    end
    n_checks++; if (count !== 8'd5) begin n_errors++; $display("FAIL cs_count got %0d exp 5", count); end
  endtask
  task automatic test_retransmit();
    pulse_start(1'b0);
    n_checks++; if (mem_addr !== 8'd0) begin n_errors++; $display("FAIL rt_rewind got %0d exp 0", mem_addr); end
    for (int k = 0; k < 3; k++) begin
      pulse_next();
      n_checks++; if (mem_addr !== 8'(k)) begin n_errors++; $display("FAIL rt_addr[%0d] got %0d exp %0d", k, mem_addr, k); end
    end
    pulse_start(1'b1);
    n_checks++; if (count !== 8'd3) begin n_errors++; $display("FAIL rt_count got %0d exp 3", count); end
    pulse_done();
    n_checks++; if (mem_addr !== 8'd2) begin n_errors++; $display("FAIL rt_idle_addr got %0d exp 2", mem_addr); end
  endtask
  task automatic test_write_in_stream();
    pulse_start(1'b1);
    pulse_next();
    wr_valid = 1'b1;
    wr_data = 8'h5A;
    n_checks++; if (wr_ready !== 1'b1) begin n_errors++; $display("FAIL ws_ready_pre got %b exp 1", wr_ready); end
    tick();
    wr_data = 8'h66;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if ({wr_ready, mem_we} !== 2'b00) begin n_errors++; $display("FAIL ws_blocked[%0d] got %b exp 00", k, {wr_ready, mem_we}); end
      tick();
    end
    wr_valid = 1'b0;
    pulse_done();
    n_checks++; if (mem_we !== 1'b1) begin n_errors++; $display("FAIL ws_drain_we got %b exp 1", mem_we); end
    n_checks++; if (mem_addr !== 8'd5) begin n_errors++; $display("FAIL ws_drain_addr got %0d exp 5", mem_addr); end
    n_checks++; if (mem_wdata !== 8'h5A) begin n_errors++; $display("FAIL ws_drain_data got %h exp 5a", mem_wdata); end
    tick();
    n_checks++; if (count !== 8'd4) begin n_errors++; $display("FAIL ws_count got %0d exp 4", count); end
  endtask
  task automatic test_overflow();
    do_reset();
    write_n(255);
    n_checks++; if ({full, overflow} !== 2'b10) begin n_errors++; $display("FAIL of_pre got %b exp 10", {full, overflow}); end
    n_checks++; if (count !== 8'd255) begin n_errors++; $display("FAIL of_pre_count got %0d exp 255", count); end
    wr_valid = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL of_we got %b exp 0", mem_we); end
    tick();
    n_checks++; if ({full, overflow, wr_ready} !== 3'b111) begin n_errors++; $display("FAIL of_post got %b exp 111", {full, overflow, wr_ready}); end
    n_checks++; if (count !== 8'd255) begin n_errors++; $display("FAIL of_count got %0d exp 255", count); end
  endtask
  task automatic test_wrap();
    logic [7:0] e;
    do_reset();
    write_n(254);
    pulse_start(1'b1);
    for (int k = 0; k < 11; k++) pulse_next();
    n_checks++; if (mem_addr !== 8'd10) begin n_errors++; $display("FAIL wr_rd got %0d exp 10", mem_addr); end
    pulse_done();
    pulse_start(1'b1);
    pulse_done();
    for (int i = 0; i <= 4; i++) begin
      wr_valid = (i < 4);
      wr_data = 8'hC0 + 8'(i);
      if (i > 0) begin
        e = 8'd253 + 8'(i);
        n_checks++; if ({mem_we, mem_addr} !== {1'b1, e}) begin n_errors++; $display("FAIL wrap_addr[%0d] got %b/%0d exp 1/%0d", i, mem_we, mem_addr, e); end
      end
      tick();
    end
    wr_valid = 1'b0;
    n_checks++; if (count !== 8'd248) begin n_errors++; $display("FAIL wrap_count got %0d exp 248", count); end
  endtask
  task automatic test_underrun();
    do_reset();
    write_n(2);
    pulse_start(1'b1);
    for (int k = 0; k < 3; k++) pulse_next();
    n_checks++; if ({empty, underrun, mem_addr} !== {2'b10, 8'd2}) begin n_errors++; $display("FAIL ur_pre got %b/%b/%0d exp 1/0/2", empty, underrun, mem_addr); end
    pulse_next();
    n_checks++; if ({underrun, mem_addr} !== {1'b1, 8'd2}) begin n_errors++; $display("FAIL ur_post got %b/%0d exp 1/2", underrun, mem_addr); end
    tick();
    n_checks++; if (underrun !== 1'b1) begin n_errors++; $display("FAIL ur_sticky got %b exp 1", underrun); end
  endtask
  task automatic test_reset_midpacket();
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({mem_addr, count} !== 16'd0) begin n_errors++; $display("FAIL mr_ptrs got %0d/%0d exp 0/0", mem_addr, count); end
    n_checks++; if ({empty, underrun, wr_ready} !== 3'b101) begin n_errors++; $display("FAIL mr_flags got %b exp 101", {empty, underrun, wr_ready}); end
    tick();
    reset = 1'b0;
    tick();
    pulse_next();
    n_checks++; if (mem_addr !== 8'd0) begin n_errors++; $display("FAIL mr_idle got %0d exp 0", mem_addr); end
  endtask
  initial begin
    test_reset();
    test_write5();
    test_commit_stream();
    test_retransmit();
    test_write_in_stream();
    test_overflow();
    test_wrap();
    test_underrun();
    test_reset_midpacket();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
